// File: rtl/nv_nvdla_sdp_pkg.sv
// Shared definitions for the SDP Y operand split path: FSM state encoding,
// INT8 mode flag value and the INT8 half / routing phase encodings.
package nv_nvdla_sdp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sdp_y_state_e;

    localparam logic EW_INT8   = 1'b1;
    localparam logic HALF_LO   = 1'b0;
    localparam logic HALF_HI   = 1'b1;
    localparam logic PHASE_ALU = 1'b0;
    localparam logic PHASE_MUL = 1'b1;

endpackage

// File: rtl/nv_nvdla_sdp_y_operand_split_if.sv
// Valid/ready payload bundle used for the DMA operand input and the ALU/MUL
// operand outputs of the Y operand split block.
interface nv_nvdla_sdp_y_operand_split_if #(
    parameter int W = 64
);
    logic [W-1:0] pd;
    logic         pvld;
    logic         prdy;

    modport master (output pd, output pvld, input  prdy);
    modport slave  (input  pd, input  pvld, output prdy);
endinterface

// File: rtl/nv_nvdla_sdp_y_skid2.sv
// Two-entry valid/ready skid FIFO. The full flag is purely registered, so the
// producer never sees a combinational path from the consumer's ready.
module nv_nvdla_sdp_y_skid2 #(
    parameter int W = 64
) (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rstn,
    input  logic         push,
    input  logic [W-1:0] push_pd,
    output logic         full,
    output logic         empty_nxt,
    output logic [W-1:0] out_pd,
    output logic         out_pvld,
    input  logic         out_prdy
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt;
    logic         push_ok;
    logic         pop;

    assign full      = (cnt == 2'd2);
    assign out_pvld  = (cnt != 2'd0);
    assign out_pd    = mem[rd_ptr];
    assign pop       = out_pvld & out_prdy;
    // A push while holding two entries is refused even if a pop happens too.
    assign push_ok   = push & ~full;
    // Lets the sequencer see the FIFO going empty this cycle.
    assign empty_nxt = (cnt == 2'd0) | ((cnt == 2'd1) & pop & ~push_ok);

    // Storage, pointers and occupancy.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_pd;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_y_operand_split.sv
// Routes the element-wise DMA operand stream to the ALU and MUL operand
// channels, unpacking INT8 beats into two sign-extended output beats, and
// pulses op_done once every enabled channel has delivered its layer.
module nv_nvdla_sdp_y_operand_split
    import nv_nvdla_sdp_pkg::*;
#(
    parameter int K     = 4,
    parameter int OP_W  = 16,
    parameter int CNT_W = 13
) (
    input  logic                           nvdla_core_clk,
    input  logic                           nvdla_core_rstn,
    input  logic                           op_en_load,
    input  logic                           reg2dp_ew_alu_mem_en,
    input  logic                           reg2dp_ew_mul_mem_en,
    input  logic                           reg2dp_ew_int8,
    input  logic [CNT_W-1:0]               reg2dp_ew_beat_num,
    nv_nvdla_sdp_y_operand_split_if.slave  op_in,
    nv_nvdla_sdp_y_operand_split_if.master alu_out,
    nv_nvdla_sdp_y_operand_split_if.master mul_out,
    output logic                           op_done
);

    localparam int PD_W = K * OP_W;
    localparam logic [CNT_W:0] CNT_ONE = 1;

    sdp_y_state_e   state;
    sdp_y_state_e   state_nxt;

    logic           cfg_alu_en;
    logic           cfg_mul_en;
    logic           cfg_int8;
    logic [CNT_W:0] cfg_beat_total;

    logic [CNT_W:0] alu_cnt;
    logic [CNT_W:0] mul_cnt;
    logic           phase;
    logic           half;

    logic           both_en;
    logic           tgt_mul;
    logic           alu_cmp;
    logic           mul_cmp;
    logic           tgt_full;
    logic           tgt_cmp;
    logic           push;
    logic           in_pop;
    logic           alu_push;
    logic           mul_push;
    logic           layer_done;
    logic           start;

    logic           alu_full;
    logic           mul_full;
    logic           alu_empty_nxt;
    logic           mul_empty_nxt;

    logic [PD_W-1:0] unpack_pd;
    logic [7:0]      lane_byte;

    assign start    = (state == ST_IDLE) & op_en_load;
    assign both_en  = cfg_alu_en & cfg_mul_en;
    // With a single channel enabled the phase bit is irrelevant.
    assign tgt_mul  = both_en ? (phase == PHASE_MUL) : ~cfg_alu_en;
    assign alu_cmp  = (alu_cnt == cfg_beat_total);
    assign mul_cmp  = (mul_cnt == cfg_beat_total);
    assign tgt_full = tgt_mul ? mul_full : alu_full;
    assign tgt_cmp  = tgt_mul ? mul_cmp  : alu_cmp;

    assign push     = (state == ST_RUN) & op_in.pvld & ~tgt_full & ~tgt_cmp;
    // INT8 beats are only consumed after their upper half has been pushed.
    assign in_pop   = push & ((cfg_int8 != EW_INT8) | (half == HALF_HI));
    assign alu_push = push & ~tgt_mul;
    assign mul_push = push &  tgt_mul;

    assign op_in.prdy = in_pop;
    assign op_done    = (state == ST_DONE);

    assign layer_done = (~cfg_alu_en | alu_cmp) & (~cfg_mul_en | mul_cmp) &
                        alu_empty_nxt & mul_empty_nxt;

    // Lane unpack: pass-through for INT16, sign-extend one byte half for INT8.
    always_comb begin
        lane_byte = '0;
        unpack_pd = op_in.pd;
        if (cfg_int8 == EW_INT8) begin
            unpack_pd = '0;
            for (int i = 0; i < K; i++) begin
                lane_byte = (half == HALF_HI) ? op_in.pd[8*(K+i) +: 8] : op_in.pd[8*i +: 8];
                unpack_pd[i*OP_W +: OP_W] = {{(OP_W-8){lane_byte[7]}}, lane_byte};
            end
        end
    end

    // Layer sequencing state register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (op_en_load) begin
                    if (!reg2dp_ew_alu_mem_en && !reg2dp_ew_mul_mem_en) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (layer_done) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Layer configuration capture, beat counters and phase/half tracking.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cfg_alu_en     <= 1'b0;
            cfg_mul_en     <= 1'b0;
            cfg_int8       <= 1'b0;
            cfg_beat_total <= '0;
            alu_cnt        <= '0;
            mul_cnt        <= '0;
            phase          <= PHASE_ALU;
            half           <= HALF_LO;
        end else if (start) begin
            cfg_alu_en     <= reg2dp_ew_alu_mem_en;
            cfg_mul_en     <= reg2dp_ew_mul_mem_en;
            cfg_int8       <= reg2dp_ew_int8;
            cfg_beat_total <= {1'b0, reg2dp_ew_beat_num} + CNT_ONE;
            alu_cnt        <= '0;
            mul_cnt        <= '0;
            phase          <= PHASE_ALU;
            half           <= HALF_LO;
        end else begin
            if (alu_push) begin
                alu_cnt <= alu_cnt + CNT_ONE;
            end
            if (mul_push) begin
                mul_cnt <= mul_cnt + CNT_ONE;
            end
            if (push && (cfg_int8 == EW_INT8)) begin
                half <= ~half;
            end
            if (in_pop && both_en) begin
                phase <= ~phase;
            end
        end
    end

    nv_nvdla_sdp_y_skid2 #(.W(PD_W)) u_alu_skid (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .push            (alu_push),
        .push_pd         (unpack_pd),
        .full            (alu_full),
        .empty_nxt       (alu_empty_nxt),
        .out_pd          (alu_out.pd),
        .out_pvld        (alu_out.pvld),
        .out_prdy        (alu_out.prdy)
    );

    nv_nvdla_sdp_y_skid2 #(.W(PD_W)) u_mul_skid (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .push            (mul_push),
        .push_pd         (unpack_pd),
        .full            (mul_full),
        .empty_nxt       (mul_empty_nxt),
        .out_pd          (mul_out.pd),
        .out_pvld        (mul_out.pvld),
        .out_prdy        (mul_out.prdy)
    );

endmodule

// File: tb/tb_nv_nvdla_sdp_y_operand_split.sv
// Self-checking bench for the SDP Y operand split block.
module tb_nv_nvdla_sdp_y_operand_split;

    logic        nvdla_core_clk = 1'b0;
    logic        nvdla_core_rstn;
    logic        op_en_load;
    logic        alu_en;
    logic        mul_en;
    logic        int8;
    logic [12:0] beat_num;
    logic        op_done;

    nv_nvdla_sdp_y_operand_split_if #(.W(64)) op_if ();
    nv_nvdla_sdp_y_operand_split_if #(.W(64)) alu_if ();
    nv_nvdla_sdp_y_operand_split_if #(.W(64)) mul_if ();

    nv_nvdla_sdp_y_operand_split #(.K(4), .OP_W(16), .CNT_W(13)) dut (
        .nvdla_core_clk       (nvdla_core_clk),
        .nvdla_core_rstn      (nvdla_core_rstn),
        .op_en_load           (op_en_load),
        .reg2dp_ew_alu_mem_en (alu_en),
        .reg2dp_ew_mul_mem_en (mul_en),
        .reg2dp_ew_int8       (int8),
        .reg2dp_ew_beat_num   (beat_num),
        .op_in                (op_if),
        .alu_out              (alu_if),
        .mul_out              (mul_if),
        .op_done              (op_done)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    typedef struct {
        logic        a;
        logic        m;
        logic        i8;
        logic [12:0] bn;
        int          n_in;
        int          exp_alu;
        int          exp_mul;
    } vec_t;

    vec_t        tbl [6];
    logic [63:0] stim [$];
    logic [63:0] drv_q [$];
    logic [63:0] exp_q [2][$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cnt = 0, pv_cyc = 0, done_cnt = 0, done_cyc = 0, prdy_cnt = 0;
    int load_cyc = 0;
    int pop_cnt [2] = '{0, 0};
    int last_acc_cyc [2] = '{0, 0};
    int base_done, base_acc, base_pv, base_prdy, base_pop0, base_pop1;
    logic        cur_a, cur_m, cur_i8;
    logic        force0 [2] = '{1'b0, 1'b0};
    logic        bp = 1'b0;
    logic        prev_stall [2] = '{1'b0, 1'b0};
    logic [63:0] prev_pd [2] = '{64'd0, 64'd0};

    always @(posedge nvdla_core_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge nvdla_core_clk);
        #2;
    endtask

    function automatic logic [63:0] unpack8(input logic [63:0] b, input bit hi);
        logic [63:0]        r;
        logic signed [7:0]  by;
        logic signed [15:0] s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            by = b[(hi ? 32 : 0) + 8*i +: 8];
            s  = by;
            r[16*i +: 16] = s;
        end
        return r;
    endfunction

    task automatic model_push(input int j, input logic [63:0] b);
        int ch;
        if (cur_a && cur_m) ch = j % 2;
        else                ch = cur_a ? 0 : 1;
        if (cur_i8) begin
            exp_q[ch].push_back(unpack8(b, 1'b0));
            exp_q[ch].push_back(unpack8(b, 1'b1));
        end else begin
            exp_q[ch].push_back(b);
        end
    endtask

    task automatic mon_ch(input int ch, input logic vld, input logic rdy, input logic [63:0] pd);
        logic [63:0] e;
        if (prev_stall[ch]) begin
            chk($sformatf("ch%0d_hold_vld", ch), 64'(vld), 64'd1);
            chk($sformatf("ch%0d_hold_pd", ch), pd, prev_pd[ch]);
        end
        if (vld && rdy) begin
            if (exp_q[ch].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ch%0d_extra: got beat %h expected none", ch, pd);
            end else begin
                e = exp_q[ch].pop_front();
                chk($sformatf("ch%0d_data", ch), pd, e);
            end
            pop_cnt[ch]++;
            last_acc_cyc[ch] = cyc;
        end
        prev_stall[ch] = vld && !rdy;
        prev_pd[ch]    = pd;
    endtask

    // Output monitor / scoreboard
    initial begin
        forever begin
            @(negedge nvdla_core_clk);
            if (!nvdla_core_rstn) begin
                prev_stall[0] = 1'b0;
                prev_stall[1] = 1'b0;
            end else begin
                if (op_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (op_if.prdy) prdy_cnt++;
                mon_ch(0, alu_if.pvld, alu_if.prdy, alu_if.pd);
                mon_ch(1, mul_if.pvld, mul_if.prdy, mul_if.pd);
            end
        end
    end

    // Input driver
    initial begin
        logic fire;
        op_if.pvld = 1'b0;
        op_if.pd   = '0;
        forever begin
            @(negedge nvdla_core_clk);
            fire = nvdla_core_rstn && op_if.pvld && op_if.prdy;
            if (nvdla_core_rstn && op_if.pvld) pv_cyc++;
            @(posedge nvdla_core_clk);
            #1;
            if (fire && drv_q.size() > 0) begin
                void'(drv_q.pop_front());
                acc_cnt++;
            end
            if (drv_q.size() > 0) begin
                op_if.pd   = drv_q[0];
                op_if.pvld = 1'b1;
            end else begin
                op_if.pvld = 1'b0;
            end
        end
    end

    // Output sinks
    initial begin
        alu_if.prdy = 1'b0;
        mul_if.prdy = 1'b0;
        forever begin
            @(posedge nvdla_core_clk);
            #1;
            alu_if.prdy = force0[0] ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
            mul_if.prdy = force0[1] ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    task automatic start_layer(input logic a, input logic m, input logic i8,
                               input logic [12:0] bn, input bit use_model);
        base_done = done_cnt;
        base_acc  = acc_cnt;
        base_pv   = pv_cyc;
        base_prdy = prdy_cnt;
        base_pop0 = pop_cnt[0];
        base_pop1 = pop_cnt[1];
        cur_a = a; cur_m = m; cur_i8 = i8;
        tick();
        alu_en = a; mul_en = m; int8 = i8; beat_num = bn;
        op_en_load = 1'b1;
        load_cyc = cyc;
        tick();
        op_en_load = 1'b0;
        for (int j = 0; j < stim.size(); j++) begin
            drv_q.push_back(stim[j]);
            if (use_model) model_push(j, stim[j]);
        end
    endtask

    task automatic finish_layer(input string tag, input int exp_alu, input int exp_mul);
        int t;
        t = 0;
        while (done_cnt == base_done && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no op_done after %0d cycles required 1 pulse", tag, t);
        end
        repeat (3) tick();
        chk({tag, "_done_pulses"}, 64'(done_cnt - base_done), 64'd1);
        chk({tag, "_alu_beats"}, 64'(pop_cnt[0] - base_pop0), 64'(exp_alu));
        chk({tag, "_mul_beats"}, 64'(pop_cnt[1] - base_pop1), 64'(exp_mul));
        chk({tag, "_alu_left"}, 64'(exp_q[0].size()), 64'd0);
        chk({tag, "_mul_left"}, 64'(exp_q[1].size()), 64'd0);
        chk({tag, "_in_left"}, 64'(drv_q.size()), 64'd0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 13'd2, 3, 3, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 13'd1, 4, 2, 2};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 13'd3, 4, 4, 4};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 13'd5, 3, 6, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 13'd4, 5, 0, 5};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 13'd7, 4, 0, 8};

        nvdla_core_rstn = 1'b0;
        op_en_load = 1'b0;
        alu_en = 1'b0; mul_en = 1'b0; int8 = 1'b0; beat_num = '0;
        repeat (3) tick();
        chk("rst_alu_vld", 64'(alu_if.pvld), 64'd0);
        chk("rst_mul_vld", 64'(mul_if.pvld), 64'd0);
        chk("rst_in_rdy", 64'(op_if.prdy), 64'd0);
        chk("rst_done", 64'(op_done), 64'd0);
        chk("rst_alu_pd", alu_if.pd, 64'd0);
        chk("rst_mul_pd", mul_if.pd, 64'd0);
        nvdla_core_rstn = 1'b1;
        tick();

        // Table of layers
        for (int i = 0; i < 6; i++) begin
            stim.delete();
            if (i == 0) begin
                stim.push_back(64'h0004_0003_0002_0001);
                stim.push_back(64'h0008_0007_0006_0005);
                stim.push_back(64'h000C_000B_000A_0009);
            end else begin
                for (int j = 0; j < tbl[i].n_in; j++) stim.push_back({$urandom, $urandom});
            end
            bp = (i >= 2);
            start_layer(tbl[i].a, tbl[i].m, tbl[i].i8, tbl[i].bn, 1'b1);
            finish_layer($sformatf("tbl%0d", i), tbl[i].exp_alu, tbl[i].exp_mul);
            chk($sformatf("tbl%0d_in_pops", i), 64'(acc_cnt - base_acc), 64'(tbl[i].n_in));
            if (i == 0) chk("t1_done_lat", 64'(done_cyc - last_acc_cyc[0]), 64'd1);
        end
        bp = 1'b0;

        // INT8 MUL-only with fixed signed bytes
        stim.delete();
        stim.push_back(64'h0504_0302_FF01_7F80);
        exp_q[1].push_back(64'hFFFF_0001_007F_FF80);
        exp_q[1].push_back(64'h0005_0004_0003_0002);
        start_layer(1'b0, 1'b1, 1'b1, 13'd1, 1'b0);
        finish_layer("t2", 0, 2);
        chk("t2_in_cycles", 64'(pv_cyc - base_pv), 64'd2);
        chk("t2_in_pops", 64'(acc_cnt - base_acc), 64'd1);
        chk("t2_prdy_cycles", 64'(prdy_cnt - base_prdy), 64'd1);

        // Both channels, MUL held off for 10 cycles
        stim.delete();
        for (int j = 0; j < 12; j++) stim.push_back({$urandom, $urandom});
        force0[1] = 1'b1;
        start_layer(1'b1, 1'b1, 1'b0, 13'd5, 1'b1);
        repeat (10) tick();
        chk("t4_acc_stall", 64'(acc_cnt - base_acc), 64'd5);
        chk("t4_mul_vld", 64'(mul_if.pvld), 64'd1);
        chk("t4_mul_pending", 64'(exp_q[1].size()), 64'd6);
        chk("t4_alu_pending", 64'(exp_q[0].size()), 64'd3);
        force0[1] = 1'b0;
        finish_layer("t4", 6, 6);

        // No channel enabled
        stim.delete();
        start_layer(1'b0, 1'b0, 1'b0, 13'd3, 1'b1);
        finish_layer("t5", 0, 0);
        chk("t5_done_lat", 64'(done_cyc - load_cyc), 64'd1);
        chk("t5_prdy_never", 64'(prdy_cnt - base_prdy), 64'd0);

        // Reset mid-layer
        stim.delete();
        for (int j = 0; j < 4; j++) stim.push_back({$urandom, $urandom});
        force0[0] = 1'b1;
        start_layer(1'b1, 1'b0, 1'b0, 13'd3, 1'b1);
        repeat (6) tick();
        chk("t6_alu_vld_before", 64'(alu_if.pvld), 64'd1);
        nvdla_core_rstn = 1'b0;
        #1;
        chk("t6_alu_vld_rst", 64'(alu_if.pvld), 64'd0);
        chk("t6_mul_vld_rst", 64'(mul_if.pvld), 64'd0);
        chk("t6_in_rdy_rst", 64'(op_if.prdy), 64'd0);
        drv_q.delete();
        exp_q[0].delete();
        exp_q[1].delete();
        force0[0] = 1'b0;
        repeat (3) tick();
        chk("t6_no_done", 64'(done_cnt - base_done), 64'd0);
        nvdla_core_rstn = 1'b1;
        tick();
        stim.delete();
        for (int j = 0; j < tbl[2].n_in; j++) stim.push_back({$urandom, $urandom});
        start_layer(tbl[2].a, tbl[2].m, tbl[2].i8, tbl[2].bn, 1'b1);
        finish_layer("t6_after", tbl[2].exp_alu, tbl[2].exp_mul);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
